// File: rtl/loteria_entrada.sv
// Input conditioner for the Loteria FSM: synchronises and debounces the raw buttons and digit
// switches, turns presses into single-cycle pulses and enforces the digit/finish/clear sequencing.
module loteria_entrada #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SYNC_STAGES     = 2,
    parameter int MAX_DIGITS      = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_insert_n,
    input  logic       key_finish_n,
    input  logic       key_clear_n,
    input  logic [3:0] sw_num,
    output logic       insert_pulse,
    output logic       finish_pulse,
    output logic       clear_pulse,
    output logic [3:0] num_out,
    output logic [2:0] digit_count,
    output logic       err
);

    // The counter only ever needs to hold DEBOUNCE_CYCLES-1 before the level flips.
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]    MAX_CNT  = 3'(MAX_DIGITS);

    localparam int KEY_INSERT = 0;
    localparam int KEY_FINISH = 1;
    localparam int KEY_CLEAR  = 2;

    logic [2:0] raw_keys;
    logic [2:0] press;

    assign raw_keys = {key_clear_n, key_finish_n, key_insert_n};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_key
            logic [SYNC_STAGES-1:0] sync_reg;
            logic                   db_reg;
            logic [CW-1:0]          cnt_reg;
            logic                   synced;

            assign synced = sync_reg[SYNC_STAGES-1];

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    sync_reg <= '1;
                    db_reg   <= 1'b1;
                    cnt_reg  <= '0;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw_keys[gi]};
                    if (synced == db_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        db_reg  <= synced;
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
            end

            // A press is the debounced level about to fall; it is registered on the same edge.
            assign press[gi] = db_reg && !synced && (cnt_reg == CNT_LAST);
        end
    endgenerate

    logic [SYNC_STAGES*4-1:0] sw_sync_reg;
    logic [3:0]               sw_synced;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_sync_reg <= '1;
        end else begin
            sw_sync_reg <= {sw_sync_reg[(SYNC_STAGES-1)*4-1:0], sw_num};
        end
    end

    assign sw_synced = sw_sync_reg[SYNC_STAGES*4-1 -: 4];

    logic       insert_pulse_reg;
    logic       finish_pulse_reg;
    logic       clear_pulse_reg;
    logic [3:0] num_out_reg;
    logic [2:0] digit_count_reg;
    logic       err_reg;
    logic       locked_reg;

    // Coinciding events resolve clear > finish > insert; losers are simply dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            insert_pulse_reg <= 1'b0;
            finish_pulse_reg <= 1'b0;
            clear_pulse_reg  <= 1'b0;
            num_out_reg      <= 4'd0;
            digit_count_reg  <= 3'd0;
            err_reg          <= 1'b0;
            locked_reg       <= 1'b0;
        end else begin
            insert_pulse_reg <= 1'b0;
            finish_pulse_reg <= 1'b0;
            clear_pulse_reg  <= 1'b0;
            if (press[KEY_CLEAR]) begin
                clear_pulse_reg <= 1'b1;
                digit_count_reg <= 3'd0;
                num_out_reg     <= 4'd0;
                err_reg         <= 1'b0;
                locked_reg      <= 1'b0;
            end else if (press[KEY_FINISH]) begin
                if (digit_count_reg == MAX_CNT && !locked_reg) begin
                    finish_pulse_reg <= 1'b1;
                    locked_reg       <= 1'b1;
                end
            end else if (press[KEY_INSERT]) begin
                if (!locked_reg && digit_count_reg != MAX_CNT) begin
                    if (sw_synced > 4'd9) begin
                        err_reg <= 1'b1;
                    end else begin
                        num_out_reg      <= sw_synced;
                        insert_pulse_reg <= 1'b1;
                        digit_count_reg  <= digit_count_reg + 3'd1;
                        err_reg          <= 1'b0;
                    end
                end
            end
        end
    end

    assign insert_pulse = insert_pulse_reg;
    assign finish_pulse = finish_pulse_reg;
    assign clear_pulse  = clear_pulse_reg;
    assign num_out      = num_out_reg;
    assign digit_count  = digit_count_reg;
    assign err          = err_reg;

endmodule

// File: tb/tb_loteria_entrada.sv
// Directed bench for loteria_entrada with a short debounce: timing sequences by hand plus a
// table of press transactions with hand-computed pulse counts and output values.
module tb_loteria_entrada;

    localparam int D = 4;
    localparam int S = 2;
    localparam int LAT = S + D;  // relative edge of the pulse when edge 1 first samples the press

    logic       clk;
    logic       reset;
    logic       key_insert_n;
    logic       key_finish_n;
    logic       key_clear_n;
    logic [3:0] sw_num;
    logic       insert_pulse;
    logic       finish_pulse;
    logic       clear_pulse;
    logic [3:0] num_out;
    logic [2:0] digit_count;
    logic       err;

    loteria_entrada #(
        .DEBOUNCE_CYCLES(D),
        .SYNC_STAGES    (S),
        .MAX_DIGITS     (5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key_insert_n(key_insert_n),
        .key_finish_n(key_finish_n),
        .key_clear_n (key_clear_n),
        .sw_num      (sw_num),
        .insert_pulse(insert_pulse),
        .finish_pulse(finish_pulse),
        .clear_pulse (clear_pulse),
        .num_out     (num_out),
        .digit_count (digit_count),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int ins_cnt = 0;
    int fin_cnt = 0;
    int clr_cnt = 0;

    always @(negedge clk) begin
        if (insert_pulse) ins_cnt++;
        if (finish_pulse) fin_cnt++;
        if (clear_pulse)  clr_cnt++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_insert_pulse"}, int'(insert_pulse), 0);
        check({tag, "_finish_pulse"}, int'(finish_pulse), 0);
        check({tag, "_clear_pulse"},  int'(clear_pulse), 0);
        check({tag, "_num_out"},      int'(num_out), 0);
        check({tag, "_digit_count"},  int'(digit_count), 0);
        check({tag, "_err"},          int'(err), 0);
    endtask

    // Holds key_insert_n low (already driven) for n edges, reporting first pulse edge and pulse count.
    task automatic watch_insert(input int n, output int first, output int count);
        first = -1;
        count = 0;
        for (int r = 1; r <= n; r++) begin
            @(posedge clk);
            @(negedge clk);
            if (insert_pulse) begin
                if (first < 0) first = r;
                count++;
            end
        end
    endtask

    typedef struct {
        logic [2:0] keys;   // bit0 insert, bit1 finish, bit2 clear
        logic [3:0] sw;
        int         e_ins;
        int         e_fin;
        int         e_clr;
        logic [3:0] e_num;
        logic [2:0] e_cnt;
        logic       e_err;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    initial begin
        int first;
        int count;
        int ins0;
        int fin0;
        int clr0;

        vecs[0]  = '{3'b001, 4'd12, 0, 0, 0, 4'd5, 3'd2, 1'b1};
        vecs[1]  = '{3'b001, 4'd0,  1, 0, 0, 4'd0, 3'd3, 1'b0};
        vecs[2]  = '{3'b010, 4'd0,  0, 0, 0, 4'd0, 3'd3, 1'b0};
        vecs[3]  = '{3'b001, 4'd7,  1, 0, 0, 4'd7, 3'd4, 1'b0};
        vecs[4]  = '{3'b001, 4'd9,  1, 0, 0, 4'd9, 3'd5, 1'b0};
        vecs[5]  = '{3'b001, 4'd3,  0, 0, 0, 4'd9, 3'd5, 1'b0};
        vecs[6]  = '{3'b001, 4'd11, 0, 0, 0, 4'd9, 3'd5, 1'b0};
        vecs[7]  = '{3'b010, 4'd0,  0, 1, 0, 4'd9, 3'd5, 1'b0};
        vecs[8]  = '{3'b001, 4'd2,  0, 0, 0, 4'd9, 3'd5, 1'b0};
        vecs[9]  = '{3'b010, 4'd2,  0, 0, 0, 4'd9, 3'd5, 1'b0};
        vecs[10] = '{3'b100, 4'd2,  0, 0, 1, 4'd0, 3'd0, 1'b0};
        vecs[11] = '{3'b001, 4'd4,  1, 0, 0, 4'd4, 3'd1, 1'b0};
        vecs[12] = '{3'b001, 4'd10, 0, 0, 0, 4'd4, 3'd1, 1'b1};
        vecs[13] = '{3'b101, 4'd6,  0, 0, 1, 4'd0, 3'd0, 1'b0};
        vecs[14] = '{3'b001, 4'd1,  1, 0, 0, 4'd1, 3'd1, 1'b0};

        reset        = 1'b0;
        key_insert_n = 1'b1;
        key_finish_n = 1'b1;
        key_clear_n  = 1'b1;
        sw_num       = 4'd5;
        #1;
        check_all_zero("reset");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // Single clean press: pulse on relative edge S+D, exactly once while held.
        key_insert_n = 1'b0;
        watch_insert(20, first, count);
        check("t1_first_pulse_edge", first, LAT);
        check("t1_pulse_count", count, 1);
        check("t1_num_out", int'(num_out), 5);
        check("t1_digit_count", int'(digit_count), 1);
        check("t1_err", int'(err), 0);
        $display("t1 clean press: first=%0d count=%0d num=%0d cnt=%0d", first, count, num_out, digit_count);
        key_insert_n = 1'b1;
        repeat (12) @(negedge clk);

        // Bouncing press: 2-cycle toggles never satisfy the debounce, then a steady low does.
        ins0 = ins_cnt;
        for (int c = 0; c < 12; c++) begin
            key_insert_n = ((c / 2) % 2) == 1;
            @(negedge clk);
        end
        check("t2_bounce_pulses", ins_cnt - ins0, 0);
        key_insert_n = 1'b0;
        watch_insert(20, first, count);
        check("t2_first_pulse_edge", first, LAT);
        check("t2_pulse_count", count, 1);
        check("t2_digit_count", int'(digit_count), 2);
        $display("t2 bounced press: first=%0d count=%0d cnt=%0d", first, count, digit_count);
        key_insert_n = 1'b1;
        repeat (12) @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            ins0 = ins_cnt;
            fin0 = fin_cnt;
            clr0 = clr_cnt;
            sw_num       = vecs[i].sw;
            key_insert_n = !vecs[i].keys[0];
            key_finish_n = !vecs[i].keys[1];
            key_clear_n  = !vecs[i].keys[2];
            repeat (12) @(negedge clk);
            key_insert_n = 1'b1;
            key_finish_n = 1'b1;
            key_clear_n  = 1'b1;
            repeat (12) @(negedge clk);
            check($sformatf("v%0d_insert_pulses", i), ins_cnt - ins0, vecs[i].e_ins);
            check($sformatf("v%0d_finish_pulses", i), fin_cnt - fin0, vecs[i].e_fin);
            check($sformatf("v%0d_clear_pulses", i),  clr_cnt - clr0, vecs[i].e_clr);
            check($sformatf("v%0d_num_out", i),       int'(num_out), int'(vecs[i].e_num));
            check($sformatf("v%0d_digit_count", i),   int'(digit_count), int'(vecs[i].e_cnt));
            check($sformatf("v%0d_err", i),           int'(err), int'(vecs[i].e_err));
            $display("vec %0d keys=%b sw=%0d: ins=%0d fin=%0d clr=%0d num=%0d cnt=%0d err=%0d", i,
                     vecs[i].keys, vecs[i].sw, ins_cnt - ins0, fin_cnt - fin0, clr_cnt - clr0,
                     num_out, digit_count, err);
        end

        // Reset mid-debounce (counter at 2) with the key still held through release.
        sw_num       = 4'd8;
        key_insert_n = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("t6_async_reset");
        @(negedge clk);
        reset = 1'b1;
        watch_insert(15, first, count);
        check("t6_first_pulse_edge", first, LAT);
        check("t6_pulse_count", count, 1);
        check("t6_num_out", int'(num_out), 8);
        check("t6_digit_count", int'(digit_count), 1);
        $display("t6 reset mid-debounce: first=%0d count=%0d num=%0d cnt=%0d", first, count, num_out, digit_count);
        key_insert_n = 1'b1;
        repeat (8) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
